dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001: Parameter TIMEOUT_CYCLES, default 255, SHALL set the number of cycles an access may spend in REQ+WAIT_RSP before it is aborted.
REQ-002: Ports SHALL be, one per line:
- clk  in  1  sole clock, rising edge; one clock; reset is asynchronous and active-high
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  EX/MEM stage holds a memory instruction
- mem_read  in  1  load
- mem_write  in  1  store
- mem_funct3  in  3  size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, right-aligned
- dreq_valid  out  1  request to data memory
- dreq_ready  in  1  memory accepts request
- dreq_we  out  1  write request
- dreq_addr  out  32  word address {mem_addr[31:2],2'b00}
- dreq_wdata  out  32  lane-replicated store data
- dreq_be  out  4  byte enables
- drsp_valid  in  1  read data valid
- drsp_rdata  in  32  read word
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- wb_bubble  out  1  MEM/WB register captures RegWrite=0
- load_data  out  32  extended load result, valid in DONE
- misalign_err  out  1  one-cycle pulse
- timeout_err  out  1  one-cycle pulse

Function
REQ-003: FSM states SHALL be IDLE, REQ, WAIT_RSP, DONE.
REQ-004: access_start = state==IDLE & mem_valid & (mem_read|mem_write) & aligned; mem_read with mem_write both high SHALL be treated as a read.
REQ-005: Alignment: H/HU need addr[0]==0, W needs addr[1:0]==0; B always aligned.
REQ-006: Misaligned valid access in IDLE SHALL pulse misalign_err the same cycle, issue no request, stay IDLE, not assert stall_mem.
REQ-007: IDLE -> REQ on access_start; address, data, funct3, direction registered on that edge.
REQ-008: In REQ, dreq_valid=1 with dreq_we/addr/wdata/be stable until dreq_ready sampled high.
REQ-009: REQ with dreq_ready: write -> DONE; read -> WAIT_RSP.
REQ-010: drsp_valid SHALL be ignored outside WAIT_RSP; WAIT_RSP with drsp_valid -> DONE, drsp_rdata captured.
REQ-011: DONE -> IDLE unconditionally after one cycle; no new access_start is evaluated in DONE.
REQ-012: stall_mem = access_start | state==REQ | state==WAIT_RSP; low in DONE.
REQ-013: wb_bubble SHALL equal stall_mem.
REQ-014: dreq_be: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; reads use same enables.
REQ-015: dreq_wdata: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
REQ-016: load_data: lane selected by registered addr[1:0], sign-extended for B/H, zero-extended for BU/HU; held from DONE until next capture.
REQ-017: Timeout counter SHALL clear on entry to REQ, increment each cycle in REQ or WAIT_RSP; on reaching TIMEOUT_CYCLES: timeout_err pulse one cycle, dreq_valid low next cycle, go DONE, load_data=0.
REQ-018: dreq_ready and timeout in the same cycle: acceptance wins, counter ignored.

Reset
REQ-019: rst high SHALL immediately force state IDLE, counter 0, load_data 0, all outputs 0 regardless of clk.
REQ-020: Reset mid-access SHALL drop dreq_valid and stall_mem asynchronously; the in-flight access is abandoned and a late drsp_valid after reset is ignored.

Verification
REQ-021: LW addr 0x100, dreq_ready at cycle 1, drsp_valid rdata 0xDEADBEEF at cycle 3 -> stall_mem high cycles 0-3, DONE at cycle 4, load_data 0xDEADBEEF.
REQ-022: LB addr 0x103, rdata 0x80FF_0000 -> dreq_be 1000, load_data 0xFFFFFF80; LBU -> 0x00000080.
REQ-023: SH addr 0x202 wdata 0x1234, dreq_ready held low 3 cycles -> dreq_valid/addr 0x200/be 1100/wdata 0x12341234 stable 4 cycles, no WAIT_RSP.
REQ-024: LW addr 0x101 -> misalign_err 1 cycle, dreq_valid 0, stall_mem 0.
REQ-025: TIMEOUT_CYCLES=4, read accepted, no drsp_valid -> timeout_err pulse, DONE, load_data 0, then IDLE.
REQ-026: rst asserted in WAIT_RSP then drsp_valid after release -> outputs 0, state IDLE, drsp ignored.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: turns load/store instructions into
// word-wide request/response transactions and freezes the pipeline while busy.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        dreq_valid,
    input  logic        dreq_ready,
    output logic        dreq_we,
    output logic [31:0] dreq_addr,
    output logic [31:0] dreq_wdata,
    output logic [3:0]  dreq_be,
    input  logic        drsp_valid,
    input  logic [31:0] drsp_rdata,
    output logic        stall_mem,
    output logic        wb_bubble,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ      = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [1:0]       lane_q;
    logic [2:0]       funct3_q;
    logic [31:0]      load_q;

    logic        access_req;
    logic        aligned;
    logic        access_start;
    logic        busy;
    logic        rsp_take;
    logic        tmo_hit;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign access_req = mem_valid & (mem_read | mem_write);

    // funct3[1:0] gives the access size; the unused encoding 11 behaves as a word.
    always_comb begin
        aligned    = 1'b1;
        be_next    = 4'b1111;
        wdata_next = mem_wdata;
        case (mem_funct3[1:0])
            2'b00: begin
                aligned    = 1'b1;
                be_next    = 4'b0001 << mem_addr[1:0];
                wdata_next = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                aligned    = ~mem_addr[0];
                be_next    = 4'b0011 << mem_addr[1:0];
                wdata_next = {2{mem_wdata[15:0]}};
            end
            default: begin
                aligned    = (mem_addr[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = mem_wdata;
            end
        endcase
    end

    // Gated by rst so the combinational outputs are quiet during reset.
    assign access_start = ~rst & (state == IDLE) & access_req & aligned;
    assign misalign_err = ~rst & (state == IDLE) & access_req & ~aligned;

    assign busy     = (state == REQ) | (state == WAIT_RSP);
    assign rsp_take = (state == WAIT_RSP) & drsp_valid;

    // An acceptance or response in the final budget cycle beats the timeout.
    assign tmo_hit = (cnt >= CNT_LAST) &
                     (((state == REQ) & ~dreq_ready) | ((state == WAIT_RSP) & ~drsp_valid));

    always_comb begin
        shifted  = drsp_rdata >> {lane_q, 3'b000};
        load_ext = drsp_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = drsp_rdata;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (access_start) state_d = REQ;
            end
            REQ: begin
                if (dreq_ready)   state_d = we_q ? DONE : WAIT_RSP;
                else if (tmo_hit) state_d = DONE;
            end
            WAIT_RSP: begin
                if (drsp_valid | tmo_hit) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            lane_q   <= 2'd0;
            funct3_q <= 3'd0;
            load_q   <= 32'd0;
        end else begin
            state <= state_d;
            if (access_start) begin
                cnt      <= '0;
                we_q     <= mem_write & ~mem_read;
                addr_q   <= {mem_addr[31:2], 2'b00};
                wdata_q  <= wdata_next;
                be_q     <= be_next;
                lane_q   <= mem_addr[1:0];
                funct3_q <= mem_funct3;
            end else if (busy) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (rsp_take) begin
                load_q <= load_ext;
            end else if (tmo_hit) begin
                load_q <= 32'd0;
            end
        end
    end

    assign dreq_valid  = (state == REQ);
    assign dreq_we     = we_q;
    assign dreq_addr   = addr_q;
    assign dreq_wdata  = wdata_q;
    assign dreq_be     = be_q;
    assign stall_mem   = access_start | busy;
    assign wb_bubble   = stall_mem;
    assign load_data   = load_q;
    assign timeout_err = tmo_hit;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction-level model.
module tb_dmem_access_ctrl;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata;
    logic        dreq_valid, dreq_ready, dreq_we;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_be;
    logic        drsp_valid;
    logic [31:0] drsp_rdata;
    logic        stall_mem, wb_bubble, misalign_err, timeout_err;
    logic [31:0] load_data;

    int checks = 0;
    int errors = 0;

    // Model of the outstanding access: issued, handed off, finishing.
    bit          m_busy, m_acc, m_fin;
    int          m_age;
    bit          m_we;
    logic [31:0] m_addr, m_wdata, m_load;
    logic [2:0]  m_f3;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
        .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_be(dreq_be),
        .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata),
        .stall_mem(stall_mem), .wb_bubble(wb_bubble), .load_data(load_data),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic int unsigned sizeOf(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit isAligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % sizeOf(f3)) == 0;
    endfunction

    function automatic logic [3:0] beOf(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz = sizeOf(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] wdataOf(input logic [2:0] f3, input logic [31:0] wd);
        int unsigned sz = sizeOf(f3);
        if (sz == 1) return wd[7:0] * 32'h0101_0101;
        if (sz == 2) return wd[15:0] * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] extendLoad(input logic [31:0] rd, input logic [2:0] f3,
                                               input logic [31:0] a);
        int unsigned sz = sizeOf(f3);
        longint v;
        if (sz == 4) return rd;
        v = longint'(rd >> (8 * (a % 4))) & ((longint'(1) << (8 * sz)) - 1);
        if (!f3[2] && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    function automatic bit expStart();
        return !rst && !m_busy && !m_fin && mem_valid && (mem_read || mem_write)
               && isAligned(mem_funct3, mem_addr);
    endfunction

    function automatic bit expMisalign();
        return !rst && !m_busy && !m_fin && mem_valid && (mem_read || mem_write)
               && !isAligned(mem_funct3, mem_addr);
    endfunction

    function automatic bit expTimeout();
        bit acc_now = m_busy && !m_acc && dreq_ready;
        bit rsp_now = m_busy && m_acc && drsp_valid;
        return m_busy && !acc_now && !rsp_now && (m_age >= int'(T) - 1);
    endfunction

    task automatic modelReset();
        m_busy = 0; m_acc = 0; m_fin = 0; m_age = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_f3 = '0; m_load = '0;
    endtask

    // Advance the model by one clock using the inputs that were present at the edge.
    task automatic modelAdvance();
        bit tmo;
        if (rst) begin
            modelReset();
            return;
        end
        tmo = expTimeout();
        if (m_fin) begin
            m_fin = 0;
        end else if (!m_busy) begin
            if (expStart()) begin
                m_busy = 1; m_acc = 0; m_age = 0;
                m_we = mem_write && !mem_read;
                m_addr = mem_addr; m_wdata = mem_wdata; m_f3 = mem_funct3;
            end
        end else if (!m_acc && dreq_ready) begin
            if (m_we) begin
                m_busy = 0; m_fin = 1;
            end else begin
                m_acc = 1; m_age++;
            end
        end else if (m_acc && drsp_valid) begin
            m_busy = 0; m_fin = 1;
            m_load = extendLoad(drsp_rdata, m_f3, m_addr);
        end else if (tmo) begin
            m_busy = 0; m_fin = 1; m_load = '0;
        end else begin
            m_age++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAll();
        bit st = expStart();
        bit rq = m_busy && !m_acc;
        checkOutput("stall_mem", 32'(stall_mem), 32'(st || m_busy));
        checkOutput("wb_bubble", 32'(wb_bubble), 32'(st || m_busy));
        checkOutput("dreq_valid", 32'(dreq_valid), 32'(rq));
        checkOutput("misalign_err", 32'(misalign_err), 32'(expMisalign()));
        checkOutput("timeout_err", 32'(timeout_err), 32'(expTimeout()));
        checkOutput("load_data", load_data, m_load);
        if (rq) begin
            checkOutput("dreq_we", 32'(dreq_we), 32'(m_we));
            checkOutput("dreq_addr", dreq_addr, m_addr & ~32'd3);
            checkOutput("dreq_be", 32'(dreq_be), 32'(beOf(m_f3, m_addr)));
            checkOutput("dreq_wdata", dreq_wdata, wdataOf(m_f3, m_wdata));
        end
    endtask

    // One clock: commit model at the edge, drive new inputs at negedge, compare.
    task automatic applyStimulus(input logic mv, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic rdy, input logic rv,
                                 input logic [31:0] rdat);
        @(posedge clk);
        modelAdvance();
        @(negedge clk);
        mem_valid = mv; mem_read = rd; mem_write = wr; mem_funct3 = f3;
        mem_addr = addr; mem_wdata = wd; dreq_ready = rdy; drsp_valid = rv;
        drsp_rdata = rdat;
        #1;
        checkAll();
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        applyStimulus(1'b1, rd, wr, f3, addr, wd, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic quiet(input logic rdy, input logic rv, input logic [31:0] rdat);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, rdy, rv, rdat);
    endtask

    // Asynchronous reset in the middle of a cycle, held across one edge.
    task automatic asyncReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_stall", 32'(stall_mem), 32'd0);
        checkOutput("rst_dreq_valid", 32'(dreq_valid), 32'd0);
        checkOutput("rst_load", load_data, 32'd0);
        checkAll();
        quiet(1'b0, 1'b0, 32'd0);
        checkOutput("rst_dreq_we", 32'(dreq_we), 32'd0);
        checkOutput("rst_dreq_addr", dreq_addr, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 0; mem_read = 0; mem_write = 0; mem_funct3 = 0;
        mem_addr = 0; mem_wdata = 0; dreq_ready = 0; drsp_valid = 0; drsp_rdata = 0;
        modelReset();
        #1;
        checkOutput("reset_stall", 32'(stall_mem), 32'd0);
        checkOutput("reset_load", load_data, 32'd0);
        quiet(1'b0, 1'b0, 32'd0);
        quiet(1'b0, 1'b0, 32'd0);
        rst = 1'b0;

        // LW 0x100, accepted cycle 1, response cycle 3, DONE cycle 4
        issue(1'b1, 1'b0, 3'b010, 32'h100, 32'd0);
        checkOutput("lw_c0_stall", 32'(stall_mem), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b1, 1'b0, 32'd0);
        checkOutput("lw_c1_valid", 32'(dreq_valid), 32'd1);
        checkOutput("lw_c1_addr", dreq_addr, 32'h100);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 1'b0, 32'd0);
        checkOutput("lw_c2_stall", 32'(stall_mem), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("lw_c3_stall", 32'(stall_mem), 32'd1);
        quiet(1'b0, 1'b0, 32'd0);
        checkOutput("lw_c4_stall", 32'(stall_mem), 32'd0);
        checkOutput("lw_c4_load", load_data, 32'hDEAD_BEEF);
        quiet(1'b0, 1'b0, 32'd0);

        // Read accepted but never answered: timeout after 4 cycles
        issue(1'b1, 1'b0, 3'b010, 32'h40, 32'd0);
        quiet(1'b1, 1'b0, 32'd0);
        quiet(1'b0, 1'b0, 32'd0);
        checkOutput("tmo_c2_err", 32'(timeout_err), 32'd0);
        quiet(1'b0, 1'b0, 32'd0);
        checkOutput("tmo_c3_err", 32'(timeout_err), 32'd0);
        quiet(1'b0, 1'b0, 32'd0);
        checkOutput("tmo_c4_err", 32'(timeout_err), 32'd1);
        quiet(1'b0, 1'b0, 32'd0);
        checkOutput("tmo_c5_err", 32'(timeout_err), 32'd0);
        checkOutput("tmo_c5_load", load_data, 32'd0);
        checkOutput("tmo_c5_stall", 32'(stall_mem), 32'd0);
        quiet(1'b0, 1'b0, 32'd0);

        // LB / LBU at byte lane 3
        for (int k = 0; k < 2; k++) begin
            issue(1'b1, 1'b0, (k == 0) ? 3'b000 : 3'b100, 32'h103, 32'd0);
            quiet(1'b1, 1'b0, 32'd0);
            checkOutput("lb_be", 32'(dreq_be), 32'b1000);
            quiet(1'b0, 1'b1, 32'h80FF_0000);
            quiet(1'b0, 1'b0, 32'd0);
            checkOutput("lb_load", load_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            quiet(1'b0, 1'b0, 32'd0);
        end

        // SH 0x202 with ready low for 3 cycles, accepted in the last budget cycle
        issue(1'b0, 1'b1, 3'b001, 32'h202, 32'hFFFF_1234);
        for (int k = 0; k < 4; k++) begin
            quiet((k == 3) ? 1'b1 : 1'b0, 1'b0, 32'd0);
            checkOutput("sh_valid", 32'(dreq_valid), 32'd1);
            checkOutput("sh_addr", dreq_addr, 32'h200);
            checkOutput("sh_be", 32'(dreq_be), 32'b1100);
            checkOutput("sh_wdata", dreq_wdata, 32'h1234_1234);
            checkOutput("sh_tmo", 32'(timeout_err), 32'd0);
        end
        quiet(1'b0, 1'b0, 32'd0);
        checkOutput("sh_done_stall", 32'(stall_mem), 32'd0);
        checkOutput("sh_done_valid", 32'(dreq_valid), 32'd0);
        quiet(1'b0, 1'b0, 32'd0);

        // Misaligned LW
        issue(1'b1, 1'b0, 3'b010, 32'h101, 32'd0);
        checkOutput("mis_err", 32'(misalign_err), 32'd1);
        checkOutput("mis_stall", 32'(stall_mem), 32'd0);
        checkOutput("mis_valid", 32'(dreq_valid), 32'd0);
        quiet(1'b0, 1'b0, 32'd0);
        checkOutput("mis_err_after", 32'(misalign_err), 32'd0);
        checkOutput("mis_valid_after", 32'(dreq_valid), 32'd0);

        // Reset while waiting for a response; late response must be ignored
        issue(1'b1, 1'b0, 3'b010, 32'h80, 32'd0);
        quiet(1'b1, 1'b0, 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h80, 32'd0);
        checkOutput("rw_wait_stall", 32'(stall_mem), 32'd1);
        asyncReset();
        quiet(1'b0, 1'b1, 32'hCAFE_F00D);
        checkOutput("rw_late_stall", 32'(stall_mem), 32'd0);
        quiet(1'b0, 1'b0, 32'd0);
        checkOutput("rw_late_load", load_data, 32'd0);
        checkOutput("rw_late_valid", 32'(dreq_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, 1'($urandom), 1'($urandom),
                          3'($urandom_range(0, 7)), $urandom, $urandom,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom);
            if (i == 400) asyncReset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
